axis_1553_tx_sched: RTL and testbench
=====================================

# axis_1553_tx_sched

Message scheduler that shares one `axis_1553_encoder` between `NUM_REQ` AXI-Stream requesters. Arbitration is round-robin and happens only at message boundaries: a whole 1553 message (command/status word plus data words, delimited by `tlast`) passes uninterrupted. The block generates the encoder's 8-bit `tuser` control byte for every word. It also guards the shared encoder against stalled or over-length messages.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requester ports (2..8).
- `MAX_WORDS`, 33, maximum words per message (1 command + 32 data).
- `TIMEOUT_CYCLES`, 4096, idle-input cycles tolerated mid-message before abort (≥2).

Ports:
- `aclk` in 1: sole clock.
- `arstn` in 1: reset, asynchronous, active-low.
- `s_axis_tdata` in 16*NUM_REQ: word of requester i at [16i+15:16i].
- `s_axis_tvalid` in NUM_REQ: per-requester valid.
- `s_axis_tlast` in NUM_REQ: last word of message.
- `s_axis_tuser` in NUM_REQ: 1 selects command/status sync, 0 selects data sync. Sampled per word.
- `s_axis_tready` out NUM_REQ: per-requester ready.
- `m_axis_tdata` out 16: word to encoder.
- `m_axis_tuser` out 8: encoder control byte.
- `m_axis_tvalid` out 1 / `m_axis_tready` in 1: encoder handshake.
- `busy` out 1: message in progress (state ≠ IDLE).
- `grant_idx` out clog2(NUM_REQ): current/last granted requester.
- `msg_done` out 1: one-cycle pulse, message completed normally.
- `err_timeout` out 1: one-cycle pulse, message aborted by timeout.
- `err_overlength` out 1: one-cycle pulse, MAX_WORDS reached without tlast.

## Operation
- States: IDLE, PASS, DRAIN.
- **IDLE**
  - All `s_axis_tready` = 0.
  - If any `tvalid` is set, grant the first asserted requester at or after `rr_ptr` (wrapping), load `grant_idx`, clear `word_cnt` and `tmo_cnt`, and go to PASS.
- **PASS**
  - `s_axis_tready[grant]` = !m_axis_tvalid || m_axis_tready. Others are 0.
  - An accepted word loads the output register.
- **Control byte generated per word:**
  - [7:5] = 3'b100 if tuser=1, else 3'b010.
  - [4:3] = 0.
  - [2] = 1 only for the first word of a message (inter-message gap), else 0.
  - [1] = 0 (no inversion).
  - [0] = 1 (odd parity).
- **On an accepted word:**
  - `word_cnt`++ and `tmo_cnt` cleared.
  - If tlast: go to IDLE, pulse `msg_done`, set `rr_ptr` = grant+1 mod NUM_REQ.
  - Else if `word_cnt` becomes MAX_WORDS: go to DRAIN and pulse `err_overlength`. This word is still forwarded, with its own tuser.
- **Timeout counting:**
  - `tmo_cnt` increments only on cycles where `s_axis_tvalid[grant]` = 0 and the block could accept.
  - It holds while the output is stalled by the encoder.
  - At TIMEOUT_CYCLES-1: go to IDLE, pulse `err_timeout`, advance `rr_ptr`.
  - Later words of the aborted message are treated as a new message.
- **DRAIN**
  - `s_axis_tready[grant]` = 1. Words are discarded and nothing is driven to `m_axis`.
  - tlast accepted: go to IDLE and advance `rr_ptr`.
  - The timeout also applies, and pulses `err_timeout`.
- **Output register**
  - A single stage. `m_axis_tvalid` clears on handshake unless a new word loads on the same cycle.
  - The register is not flushed by abort: a pending word is always delivered.
- **Simultaneous events**
  - If tlast and word_cnt = MAX_WORDS occur together, treat it as normal completion with no error.
  - Requests arriving during PASS/DRAIN wait. They are never lost, since the requester holds tvalid.
- **Counter widths:** `word_cnt` is clog2(MAX_WORDS+1) bits; `tmo_cnt` is clog2(TIMEOUT_CYCLES) bits.

## Timing
- **Reset values:** all `s_axis_tready` = 0, `m_axis_tvalid` = 0, `m_axis_tdata` = 0, `m_axis_tuser` = 0, `busy` = 0, `grant_idx` = 0, all pulses = 0, `rr_ptr` = 0, state IDLE.
- **Reset mid-message:** immediately abandon the message. The output word is dropped, and no error pulse is raised.
- **Arbitration:** 1 cycle in IDLE. The first word is accepted no earlier than the cycle after, in PASS.
- **Latency:** input handshake to `m_axis_tvalid` is 1 cycle.
- **Throughput:** one word per cycle. In practice it is limited by the encoder, which holds `tready` low while transmitting.
- **Pulse timing:** `msg_done` is asserted the cycle after the tlast handshake. `err_overlength` is asserted the cycle after the MAX_WORDS-th handshake.
- **Message-to-message gap:** at least 1 IDLE cycle between the tlast of one message and the first word of the next.

## Structure
- Shared package `axis_1553_pkg`:
  - sync codes SYNC_CMD=3'b100 and SYNC_DATA=3'b010.
  - tuser bit positions (DELAY=2, INVERT=1, PARITY_ODD=0).
  - state encoding.
  - 1553 limit constant 33.
- Sub-module `rr_arbiter`: NUM_REQ requests plus ptr in, one-hot grant and index out. Purely combinational; the pointer register lives in the parent.

## Test plan
- Req0 sends a 3-word message (0x1234 tuser=1, 0xAAAA, 0x5555 tlast) with the encoder always ready. Required: m_axis tuser = 0x85, 0x41, 0x41 in order; `msg_done` pulses once; `grant_idx` = 0.
- Req0 and req1 assert tvalid continuously with 2-word messages. Required: grants alternate 0,1,0,1; no interleaving of words within a message.
- Encoder `tready` low for 500 cycles mid-message. Required: no timeout, `tmo_cnt` holds, and all words are delivered intact.
- Req1 stops after 1 word without tlast, with TIMEOUT_CYCLES=16. Required: `err_timeout` after 16 idle cycles, then IDLE; req0's pending message is granted next.
- Req0 sends 40 words, tlast on the 40th, MAX_WORDS=33. Required: 33 words are forwarded, `err_overlength` pulses once, and 7 words are drained with no m_axis activity.
- `arstn` is asserted low during the 2nd word of a message. Required: all outputs show reset values immediately; after release, a new message starts with tuser[2]=1.

Source files
------------

// File: rtl/axis_1553_pkg.sv
// Shared constants, state encoding and control-byte helper for the 1553 AXI-Stream
// transmit path.
package axis_1553_pkg;

    localparam logic [2:0] SYNC_CMD  = 3'b100;
    localparam logic [2:0] SYNC_DATA = 3'b010;

    localparam int unsigned TUSER_DELAY      = 2;
    localparam int unsigned TUSER_INVERT     = 1;
    localparam int unsigned TUSER_PARITY_ODD = 0;

    // One command/status word plus up to 32 data words.
    localparam int unsigned MIL1553_MAX_WORDS = 33;

    typedef enum logic [1:0] {
        StIdle,
        StPass,
        StDrain
    } tx_state_e;

    function automatic logic [7:0] ctrl_byte(input logic is_cmd, input logic first);
        logic [7:0] b;
        b                   = 8'h00;
        b[7:5]              = is_cmd ? SYNC_CMD : SYNC_DATA;
        b[TUSER_DELAY]      = first;
        b[TUSER_INVERT]     = 1'b0;
        b[TUSER_PARITY_ODD] = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/axis_1553_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        // Upper segment [ptr..N-1] has priority over the wrapped segment [0..ptr-1].
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!valid_o && req_i[i] && (IDX_W'(i) >= ptr_i)) begin
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
                valid_o  = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!valid_o && req_i[i] && (IDX_W'(i) < ptr_i)) begin
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_1553_tx_sched.sv
// Message-granular round-robin scheduler feeding one shared 1553 encoder, with
// per-word control-byte generation and stall/over-length guarding.
module axis_1553_tx_sched
    import axis_1553_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned MAX_WORDS      = MIL1553_MAX_WORDS,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                       aclk,
    input  logic                       arstn,
    input  logic [16*NUM_REQ-1:0]      s_axis_tdata,
    input  logic [NUM_REQ-1:0]         s_axis_tvalid,
    input  logic [NUM_REQ-1:0]         s_axis_tlast,
    input  logic [NUM_REQ-1:0]         s_axis_tuser,
    output logic [NUM_REQ-1:0]         s_axis_tready,
    output logic [15:0]                m_axis_tdata,
    output logic [7:0]                 m_axis_tuser,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       msg_done,
    output logic                       err_timeout,
    output logic                       err_overlength
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(MAX_WORDS + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);

    tx_state_e       state_q, state_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0] word_cnt_q, word_cnt_d;
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0]     m_tdata_q, m_tdata_d;
    logic [7:0]      m_tuser_q, m_tuser_d;
    logic            m_tvalid_q, m_tvalid_d;
    logic            msg_done_q, msg_done_d;
    logic            err_timeout_q, err_timeout_d;
    logic            err_overlength_q, err_overlength_d;

    logic [15:0]     req_data [NUM_REQ];
    logic [15:0]     sel_data;
    logic            sel_valid, sel_last, sel_user;
    logic            can_accept, accept, tmo_expired;
    logic [IdxW-1:0] grant_next;
    logic [CntW-1:0] word_cnt_inc;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IdxW-1:0]    arb_idx;
    logic               arb_valid;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_data[g] = s_axis_tdata[16*g +: 16];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IdxW)
    ) u_arb (
        .req_i   (s_axis_tvalid),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        sel_data     = req_data[grant_q];
        sel_valid    = s_axis_tvalid[grant_q];
        sel_last     = s_axis_tlast[grant_q];
        sel_user     = s_axis_tuser[grant_q];
        // DRAIN discards, so it never waits on the encoder.
        can_accept   = (state_q == StDrain) ||
                       ((state_q == StPass) && (!m_tvalid_q || m_axis_tready));
        accept       = can_accept && sel_valid;
        tmo_expired  = (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
        grant_next   = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + IdxW'(1);
        word_cnt_inc = word_cnt_q + CntW'(1);
    end

    always_comb begin
        s_axis_tready = '0;
        if (can_accept) begin
            s_axis_tready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        rr_ptr_d         = rr_ptr_q;
        word_cnt_d       = word_cnt_q;
        tmo_cnt_d        = tmo_cnt_q;
        m_tdata_d        = m_tdata_q;
        m_tuser_d        = m_tuser_q;
        m_tvalid_d       = m_tvalid_q;
        msg_done_d       = 1'b0;
        err_timeout_d    = 1'b0;
        err_overlength_d = 1'b0;

        // A pending word always drains, even after the message was aborted.
        if (m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    grant_d    = arb_idx;
                    word_cnt_d = '0;
                    tmo_cnt_d  = '0;
                    state_d    = StPass;
                end
            end
            StPass, StDrain: begin
                if (accept) begin
                    tmo_cnt_d = '0;
                    if (state_q == StPass) begin
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = sel_data;
                        m_tuser_d  = ctrl_byte(sel_user, word_cnt_q == '0);
                        word_cnt_d = word_cnt_inc;
                    end
                    if (sel_last) begin
                        state_d    = StIdle;
                        rr_ptr_d   = grant_next;
                        msg_done_d = (state_q == StPass);
                    end else if ((state_q == StPass) && (word_cnt_inc == CntW'(MAX_WORDS))) begin
                        state_d          = StDrain;
                        err_overlength_d = 1'b1;
                    end
                end else if (can_accept) begin
                    if (tmo_expired) begin
                        state_d       = StIdle;
                        rr_ptr_d      = grant_next;
                        err_timeout_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q          <= StIdle;
            grant_q          <= '0;
            rr_ptr_q         <= '0;
            word_cnt_q       <= '0;
            tmo_cnt_q        <= '0;
            m_tdata_q        <= '0;
            m_tuser_q        <= '0;
            m_tvalid_q       <= 1'b0;
            msg_done_q       <= 1'b0;
            err_timeout_q    <= 1'b0;
            err_overlength_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            grant_q          <= grant_d;
            rr_ptr_q         <= rr_ptr_d;
            word_cnt_q       <= word_cnt_d;
            tmo_cnt_q        <= tmo_cnt_d;
            m_tdata_q        <= m_tdata_d;
            m_tuser_q        <= m_tuser_d;
            m_tvalid_q       <= m_tvalid_d;
            msg_done_q       <= msg_done_d;
            err_timeout_q    <= err_timeout_d;
            err_overlength_q <= err_overlength_d;
        end
    end

    assign m_axis_tdata   = m_tdata_q;
    assign m_axis_tuser   = m_tuser_q;
    assign m_axis_tvalid  = m_tvalid_q;
    assign busy           = (state_q != StIdle);
    assign grant_idx      = grant_q;
    assign msg_done       = msg_done_q;
    assign err_timeout    = err_timeout_q;
    assign err_overlength = err_overlength_q;

endmodule

// File: tb/tb_axis_1553_tx_sched.sv
// Scoreboard bench for axis_1553_tx_sched: arbitration order, control bytes,
// encoder stall, timeout, over-length drain and mid-message reset.
module tb_axis_1553_tx_sched;

    localparam int unsigned NumReq        = 2;
    localparam int unsigned MaxWords      = 33;
    localparam int unsigned TimeoutCycles = 16;

    logic        aclk  = 1'b0;
    logic        arstn = 1'b1;
    logic [31:0] s_tdata  = '0;
    logic [1:0]  s_tvalid = '0;
    logic [1:0]  s_tlast  = '0;
    logic [1:0]  s_tuser  = '0;
    logic [1:0]  s_tready;
    logic [15:0] m_tdata;
    logic [7:0]  m_tuser;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        busy;
    logic        grant_idx;
    logic        msg_done, err_timeout, err_overlength;

    int checks = 0;
    int errors = 0;
    int m_hs_cnt = 0, done_cnt = 0, tmo_cnt = 0, ovl_cnt = 0;
    logic        busy_prev = 1'b0;
    logic [23:0] sb [$];
    logic [23:0] exp_w;
    int          grants [$];

    axis_1553_tx_sched #(
        .NUM_REQ        (NumReq),
        .MAX_WORDS      (MaxWords),
        .TIMEOUT_CYCLES (TimeoutCycles)
    ) dut (
        .aclk           (aclk),
        .arstn          (arstn),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tlast   (s_tlast),
        .s_axis_tuser   (s_tuser),
        .s_axis_tready  (s_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tuser   (m_tuser),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .busy           (busy),
        .grant_idx      (grant_idx),
        .msg_done       (msg_done),
        .err_timeout    (err_timeout),
        .err_overlength (err_overlength)
    );

    always #5 aclk = ~aclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_tuser(input logic cmd, input logic first);
        return {cmd ? 3'b100 : 3'b010, 2'b00, first, 1'b0, 1'b1};
    endfunction

    // Output monitor: every encoder handshake pops one expected word.
    always @(negedge aclk) begin
        if (m_tvalid && m_tready) begin
            m_hs_cnt++;
            if (sb.size() == 0) begin
                check("extra_word", 32'(sb.size()), 32'd1);
            end else begin
                exp_w = sb.pop_front();
                check("m_tdata", 32'(m_tdata), 32'(exp_w[15:0]));
                check("m_tuser", 32'(m_tuser), 32'(exp_w[23:16]));
            end
        end
        if (msg_done)       done_cnt++;
        if (err_timeout)    tmo_cnt++;
        if (err_overlength) ovl_cnt++;
        if (busy && !busy_prev) grants.push_back(int'(grant_idx));
        busy_prev = busy;
    end

    task automatic send_word(input int r, input logic [15:0] d, input logic u, input logic l,
                             input logic first, input bit push);
        bit hs;
        hs = 1'b0;
        s_tvalid[r] = 1'b1;
        s_tdata[16*r +: 16] = d;
        s_tuser[r] = u;
        s_tlast[r] = l;
        for (int c = 0; c < 3000 && !hs; c++) begin
            @(negedge aclk);
            if (s_tready[r]) hs = 1'b1;
        end
        if (!hs) begin
            check("handshake_budget", 32'(hs), 32'd1);
        end else begin
            check("grant_at_hs", 32'(grant_idx), 32'(r));
            if (push) sb.push_back({exp_tuser(u, first), d});
            @(posedge aclk);
            #1;
            if (push) begin
                check("lat_tvalid", 32'(m_tvalid), 32'd1);
                check("lat_tdata", 32'(m_tdata), 32'(d));
            end
        end
    endtask

    task automatic send_msg(input int r, input int n, input logic [15:0] base, input logic cmd,
                            input logic has_last, input int push_n);
        for (int i = 0; i < n; i++) begin
            send_word(r, base + 16'(i), (i == 0) ? cmd : 1'b0, has_last && (i == n - 1),
                      i == 0, i < push_n);
        end
        s_tvalid[r] = 1'b0;
        s_tlast[r]  = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tdata", 32'(m_tdata), 32'd0);
        check("rst_m_tuser", 32'(m_tuser), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_idx", 32'(grant_idx), 32'd0);
        check("rst_msg_done", 32'(msg_done), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        check("rst_err_overlength", 32'(err_overlength), 32'd0);
    endtask

    task automatic settle_and_check_sb();
        repeat (4) @(posedge aclk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int d0, t0, o0, h0, cyc;
        bit seen;

        #2 arstn = 1'b0;
        #1 check_reset_vals();
        repeat (3) @(posedge aclk);
        @(negedge aclk) arstn = 1'b1;
        @(posedge aclk);
        #1;

        // Two requesters streaming back-to-back 2-word messages.
        grants.delete();
        d0 = done_cnt;
        fork
            begin
                send_msg(0, 2, 16'h0100, 1'b1, 1'b1, 2);
                send_msg(0, 2, 16'h0110, 1'b1, 1'b1, 2);
            end
            begin
                send_msg(1, 2, 16'h1100, 1'b1, 1'b1, 2);
                send_msg(1, 2, 16'h1110, 1'b1, 1'b1, 2);
            end
        join
        settle_and_check_sb();
        check("alt_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            check("alt_grant", 32'(grants[i]), 32'(i % 2));
        end
        check("alt_msg_done", 32'(done_cnt - d0), 32'd4);

        // Fixed 3-word message from requester 0.
        d0 = done_cnt;
        send_word(0, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1);
        send_word(0, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(0, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b1);
        s_tvalid[0] = 1'b0;
        s_tlast[0]  = 1'b0;
        settle_and_check_sb();
        check("basic_msg_done", 32'(done_cnt - d0), 32'd1);
        check("basic_grant_idx", 32'(grant_idx), 32'd0);

        // Encoder stalls 500 cycles while the requester is idle mid-message.
        d0 = done_cnt;
        t0 = tmo_cnt;
        m_tready = 1'b0;
        send_word(0, 16'h3000, 1'b1, 1'b0, 1'b1, 1'b1);
        s_tvalid[0] = 1'b0;
        repeat (500) @(posedge aclk);
        #1;
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_held_data", 32'(m_tdata), 32'h3000);
        check("stall_no_timeout", 32'(tmo_cnt - t0), 32'd0);
        m_tready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            send_word(0, 16'h3000 + 16'(i), 1'b0, i == 3, 1'b0, 1'b1);
        end
        s_tvalid[0] = 1'b0;
        s_tlast[0]  = 1'b0;
        settle_and_check_sb();
        check("stall_msg_done", 32'(done_cnt - d0), 32'd1);
        check("stall_timeouts", 32'(tmo_cnt - t0), 32'd0);

        // Requester 1 abandons its message; requester 0 is waiting.
        grants.delete();
        t0 = tmo_cnt;
        fork
            begin
                send_msg(1, 1, 16'h2100, 1'b1, 1'b0, 1);
                seen = 1'b0;
                cyc  = 0;
                while (!seen && cyc < 60) begin
                    @(negedge aclk);
                    if (err_timeout) seen = 1'b1;
                    else cyc++;
                end
                check("tmo_idle_cycles", 32'(cyc), TimeoutCycles);
            end
            send_msg(0, 2, 16'h2000, 1'b1, 1'b1, 2);
        join
        settle_and_check_sb();
        check("tmo_pulses", 32'(tmo_cnt - t0), 32'd1);
        check("tmo_grant_count", 32'(grants.size()), 32'd2);
        if (grants.size() == 2) begin
            check("tmo_first_grant", 32'(grants[0]), 32'd1);
            check("tmo_next_grant", 32'(grants[1]), 32'd0);
        end

        // 40-word message: 33 forwarded, 7 drained.
        d0 = done_cnt;
        o0 = ovl_cnt;
        h0 = m_hs_cnt;
        send_msg(0, 40, 16'h5000, 1'b1, 1'b1, MaxWords);
        settle_and_check_sb();
        check("ovl_pulses", 32'(ovl_cnt - o0), 32'd1);
        check("ovl_forwarded", 32'(m_hs_cnt - h0), MaxWords);
        check("ovl_no_done", 32'(done_cnt - d0), 32'd0);
        check("ovl_idle_after", 32'(busy), 32'd0);

        // Reset while the second word is being offered.
        send_word(0, 16'h6000, 1'b1, 1'b0, 1'b1, 1'b1);
        s_tdata[15:0] = 16'h6001;
        s_tuser[0]    = 1'b0;
        @(negedge aclk);
        #2 arstn = 1'b0;
        #1 check_reset_vals();
        s_tvalid[0] = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk) arstn = 1'b1;
        @(posedge aclk);
        #1;
        send_msg(0, 2, 16'h7000, 1'b1, 1'b1, 2);
        settle_and_check_sb();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
